instr_fetch_unit: RTL and testbench

//   Fetch stage of the multi-cycle CPU. Holds the PC, reads instruction memory over a req/ack

---
 rtl/instr_fetch_unit.sv | 119 +++++++++++
 tb/tb_instr_fetch_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory over req/ack, holds the word in the IR
// until downstream accepts it, then computes the fall-through or jump/branch next PC.
module instr_fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [25:0] imm26,
    output logic [31:0] ir_pc,
    input  logic [31:0] ext_imm,
    input  logic        take_jump
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    localparam logic [31:0] PC_INIT = PC_RESET & 32'hFFFF_FFFC;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ir_pc_q, ir_pc_d;

    logic        fetch_done_s;
    logic        accept_s;
    logic [31:0] seq_pc_s;
    logic [31:0] br_off_s;

    // Handshake qualifiers; an ack only counts while a request is actually on the bus.
    always_comb begin
        fetch_done_s = (state_q == ST_FETCH) && req_q && imem_ack;
        accept_s     = (state_q == ST_HOLD) && valid_q && ir_ready;
        seq_pc_s     = ir_pc_q + 32'd4;
        br_off_s     = ext_imm << 2;
    end

    // Next-state, next-PC and IR capture logic.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        valid_d = valid_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        case (state_q)
            ST_FETCH: begin
                if (fetch_done_s) begin
                    ir_d    = imem_rdata;
                    ir_pc_d = pc_q;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    // Covers the first cycle after reset, where req is still low.
                    req_d   = 1'b1;
                    valid_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (accept_s) begin
                    pc_d    = take_jump ? (seq_pc_s + br_off_s) : seq_pc_s;
                    req_d   = 1'b1;
                    valid_d = 1'b0;
                    state_d = ST_FETCH;
                end else begin
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_FETCH;
                req_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    // State, PC and IR registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            pc_q    <= PC_INIT;
            ir_q    <= 32'h0000_0000;
            ir_pc_q <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
        end
    end

    always_comb begin
        imem_req  = req_q;
        imem_addr = pc_q;
        ir_valid  = valid_q;
        ir        = ir_q;
        opcode    = ir_q[31:26];
        imm26     = ir_q[25:0];
        ir_pc     = ir_pc_q;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level model of fetch/hold/accept timing and next-PC
// arithmetic, driving two instances (PC_RESET=0 and PC_RESET=0xFFFF_FFFE) from shared inputs.
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ir_ready;
    logic [31:0] ext_imm;
    logic        take_jump;

    logic        imem_req,  u2_imem_req;
    logic [31:0] imem_addr, u2_imem_addr;
    logic        ir_valid,  u2_ir_valid;
    logic [31:0] ir,        u2_ir;
    logic [5:0]  opcode,    u2_opcode;
    logic [25:0] imm26,     u2_imm26;
    logic [31:0] ir_pc,     u2_ir_pc;

    int          tests;
    int          fails;
    logic [31:0] exp_pc;

    instr_fetch_unit #(.PC_RESET(32'h0000_0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .ir(ir), .opcode(opcode), .imm26(imm26), .ir_pc(ir_pc),
        .ext_imm(ext_imm), .take_jump(take_jump)
    );

    instr_fetch_unit #(.PC_RESET(32'hFFFF_FFFE)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .imem_req(u2_imem_req), .imem_addr(u2_imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir_valid(u2_ir_valid), .ir_ready(ir_ready),
        .ir(u2_ir), .opcode(u2_opcode), .imm26(u2_imm26), .ir_pc(u2_ir_pc),
        .ext_imm(ext_imm), .take_jump(take_jump)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Both instances see identical handshakes, so the second PC is always the first minus 4.
    task automatic chk_fetching();
        chk("req", {31'd0, imem_req}, 32'd1);
        chk("addr", imem_addr, exp_pc);
        chk("valid_in_fetch", {31'd0, ir_valid}, 32'd0);
        chk("u2_addr", u2_imem_addr, exp_pc + 32'hFFFF_FFFC);
        chk("u2_req", {31'd0, u2_imem_req}, 32'd1);
    endtask

    // One instruction: ack after ack_dly waiting cycles, accept after rdy_dly stall cycles.
    task automatic fetch_one(input int ack_dly, input int rdy_dly, input bit take,
                             input logic [31:0] ext, input logic [31:0] word);
        logic [31:0] w;
        w = word;
        for (int i = 0; i <= ack_dly; i++) begin
            chk_fetching();
            imem_ack   = (i == ack_dly);
            imem_rdata = (i == ack_dly) ? w : $urandom;
            ir_ready   = 1'($urandom);
            take_jump  = 1'($urandom);
            ext_imm    = $urandom;
            @(negedge clk);
        end
        for (int i = 0; i <= rdy_dly; i++) begin
            chk("valid", {31'd0, ir_valid}, 32'd1);
            chk("req_in_hold", {31'd0, imem_req}, 32'd0);
            chk("ir", ir, w);
            chk("opcode", {26'd0, opcode}, {26'd0, w[31:26]});
            chk("imm26", {6'd0, imm26}, {6'd0, w[25:0]});
            chk("ir_pc", ir_pc, exp_pc);
            chk("addr_in_hold", imem_addr, exp_pc);
            chk("u2_ir_pc", u2_ir_pc, exp_pc + 32'hFFFF_FFFC);
            chk("u2_ir", u2_ir, w);
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            ir_ready   = (i == rdy_dly);
            take_jump  = (i == rdy_dly) ? take : 1'($urandom);
            ext_imm    = (i == rdy_dly) ? ext : $urandom;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        ir_ready = 1'b0;
        exp_pc   = take ? exp_pc + 32'd4 + (ext * 32'd4) : exp_pc + 32'd4;
    endtask

    // Called at a negedge: reset asserted mid-cycle with a late ack held through release.
    task automatic do_reset();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, ir_valid}, 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_ir_pc", ir_pc, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_u2_addr", u2_imem_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("late_ack_ir", ir, 32'd0);
        chk("late_ack_valid", {31'd0, ir_valid}, 32'd0);
        imem_ack = 1'b0;
        exp_pc   = 32'd0;
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        exp_pc     = 32'd0;
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        ir_ready   = 1'b0;
        ext_imm    = 32'd0;
        take_jump  = 1'b0;

        @(negedge clk);
        chk("reset_req", {31'd0, imem_req}, 32'd0);
        chk("reset_valid", {31'd0, ir_valid}, 32'd0);
        chk("reset_ir", ir, 32'd0);
        chk("reset_addr", imem_addr, 32'd0);
        chk("reset_u2_addr", u2_imem_addr, 32'hFFFF_FFFC);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait first fetch, then sequential fetches with a stalled ack and stalled accept.
        fetch_one(0, 0, 1'b0, 32'd0, 32'h1400_0003);
        fetch_one(3, 4, 1'b0, 32'd0, $urandom);
        fetch_one(0, 0, 1'b0, 32'h1234_5678, $urandom);
        fetch_one(0, 0, 1'b0, 32'd0, $urandom);
        // ir_pc=0x10, backward branch by -2 words.
        fetch_one(0, 0, 1'b1, 32'hFFFF_FFFE, $urandom);
        chk("branch_target", exp_pc, 32'h0000_000C);
        // Zero-offset jump equals fall-through; top bits of ext_imm shift out.
        fetch_one(1, 0, 1'b1, 32'd0, $urandom);
        fetch_one(0, 2, 1'b1, 32'hC000_0001, $urandom);

        for (int n = 0; n < 40; n++) begin
            fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom), $urandom, $urandom);
        end

        // Reset during FETCH with ack in the same cycle, then refetch from PC_RESET.
        do_reset();
        fetch_one(0, 1, 1'b0, 32'd0, $urandom);

        // Reset while an instruction is pending in HOLD.
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        imem_ack = 1'b0;
        chk("hold_before_rst", {31'd0, ir_valid}, 32'd1);
        do_reset();
        fetch_one(0, 0, 1'b1, 32'h0000_0010, $urandom);
        fetch_one(2, 1, 1'b0, 32'd0, $urandom);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
